// File: rtl/wb_pkg.sv
// wb_pkg: shared write-back codes, load funct3 constants and stage states
package wb_pkg;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_LOAD = 2'b01, WB_PC4 = 2'b10, WB_RSV = 2'b11} wb_sel_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;
endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: selects, aligns and extends load data and flags illegal loads
//   funct3  : load width/sign code
//   addr_lo : byte offset within the word
//   rdata   : word returned by data memory
//   data    : aligned, extended result
//   err     : misaligned access or undefined load funct3
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            err
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[8*addr_lo +: 8];
  assign h = rdata[16*addr_lo[1] +: 16];
  assign err = (funct3 == F3_LH || funct3 == F3_LHU) ? addr_lo[0] :
               (funct3 == F3_LW) ? |addr_lo :
               !(funct3 == F3_LB || funct3 == F3_LBU);
  // funct3[2] set means unsigned, so it gates the sign bit
  assign data = (funct3[1:0] == 2'b00) ? {{(XLEN-8){b[7] & ~funct3[2]}}, b} :
                (funct3[1:0] == 2'b01) ? {{(XLEN-16){h[15] & ~funct3[2]}}, h} : rdata;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage, drives the register-file write port and counts retires
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : handshake with the memory stage
//   in_rd/in_we/in_wb_sel/in_alu/in_pc4/in_funct3/in_addr_lo : instruction fields
//   flush               : kill any in-flight load
//   dmem_rvalid/rdata   : load response
//   RegWe/RegWr/RegWd   : registered register-file write port
//   load_busy/load_rd   : outstanding load for hazard logic
//   misalign_err        : pulse on an illegal load commit
//   instret             : retired-instruction count
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_we,
  input  logic [1:0]       in_wb_sel,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic             flush,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             RegWe,
  output logic [4:0]       RegWr,
  output logic [XLEN-1:0]  RegWd,
  output logic             load_busy,
  output logic [4:0]       load_rd,
  output logic             misalign_err,
  output logic [CNT_W-1:0] instret
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_e          state_q;
  logic            we_q, err_q, ld_we_q;
  logic [4:0]      wr_q, ld_rd_q;
  logic [XLEN-1:0] wd_q, al_data;
  logic [2:0]      ld_f3_q;
  logic [1:0]      ld_lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic            al_err;
  load_align #(.XLEN(XLEN)) u_align (
    .funct3 (ld_f3_q),
    .addr_lo(ld_lo_q),
    .rdata  (dmem_rdata),
    .data   (al_data),
    .err    (al_err)
  );
  assign in_ready     = state_q == IDLE;
  assign load_busy    = state_q == WAIT;
  assign load_rd      = load_busy ? ld_rd_q : 5'd0;
  assign RegWe        = we_q;
  assign RegWr        = wr_q;
  assign RegWd        = wd_q;
  assign misalign_err = err_q;
  assign instret      = cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      ld_we_q <= 1'b0;
      ld_rd_q <= '0;
      ld_f3_q <= '0;
      ld_lo_q <= '0;
    end else begin
      // write-port outputs are single-cycle pulses unless a commit refreshes them
      we_q  <= 1'b0;
      err_q <= 1'b0;
      wr_q  <= '0;
      wd_q  <= '0;
      case (state_q)
        IDLE: if (in_valid) begin
          if (in_wb_sel == WB_LOAD) begin
            state_q <= WAIT;
            ld_we_q <= in_we;
            ld_rd_q <= in_rd;
            ld_f3_q <= in_funct3;
            ld_lo_q <= in_addr_lo;
          end else begin
            we_q  <= in_we && in_rd != 5'd0 && in_wb_sel != WB_RSV;
            wr_q  <= in_rd;
            wd_q  <= (in_wb_sel == WB_PC4) ? in_pc4 : in_alu;
            cnt_q <= cnt_q + ONE;
          end
        end
        WAIT: if (flush) begin
          // a flush racing the response still consumes it
          state_q <= dmem_rvalid ? IDLE : DRAIN;
        end else if (dmem_rvalid) begin
          state_q <= IDLE;
          we_q    <= ld_we_q && ld_rd_q != 5'd0 && !al_err;
          wr_q    <= ld_rd_q;
          wd_q    <= al_data;
          err_q   <= al_err;
          cnt_q   <= cnt_q + ONE;
        end
        DRAIN: if (dmem_rvalid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized and directed checks of wb_stage against a transaction-level model
module tb_wb_stage;
  localparam int CW = 4;
  logic clk = 0, rst_n = 0;
  logic in_valid, in_ready, in_we, flush, dmem_rvalid;
  logic [4:0] in_rd, RegWr, load_rd;
  logic [1:0] in_wb_sel, in_addr_lo;
  logic [2:0] in_funct3;
  logic [31:0] in_alu, in_pc4, dmem_rdata, RegWd;
  logic RegWe, load_busy, misalign_err;
  logic [CW-1:0] instret;
  int checks = 0, errors = 0;
  logic m_busy, m_drain, m_we;
  logic [4:0] m_rd;
  logic [2:0] m_f3;
  logic [1:0] m_lo;
  int m_cnt;
  logic e_commit, e_we, e_err;
  logic [4:0] e_wr;
  logic [31:0] e_wd;
  wb_stage #(.XLEN(32), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_we(in_we), .in_wb_sel(in_wb_sel), .in_alu(in_alu), .in_pc4(in_pc4),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .flush(flush),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .RegWe(RegWe), .RegWr(RegWr),
    .RegWd(RegWd), .load_busy(load_busy), .load_rd(load_rd), .misalign_err(misalign_err),
    .instret(instret)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
    end
  endtask
  function automatic void ref_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d,
                                   output logic ok, output logic [31:0] v);
    int n;
    logic [31:0] mask;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    ok = (n != 0) ? (!(n == 4 && f3[2]) && (int'(lo) % n == 0)) : 1'b0;
    mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
    v = (d >> (8 * int'(lo))) & mask;
    if (!f3[2] && n > 0 && n < 4 && v[8*n-1]) v = v | ~mask;
  endfunction
  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_we = 0; m_rd = 0; m_f3 = 0; m_lo = 0; m_cnt = 0;
    e_commit = 0; e_we = 0; e_err = 0; e_wr = 0; e_wd = 0;
  endtask
  task automatic predict();
    logic ok;
    logic [31:0] v;
    e_commit = 0; e_we = 0; e_err = 0; e_wr = 0; e_wd = 0;
    if (!m_busy && !m_drain) begin
      if (in_valid && in_wb_sel == 2'b01) begin
        m_busy = 1; m_rd = in_rd; m_f3 = in_funct3; m_lo = in_addr_lo; m_we = in_we;
      end else if (in_valid) begin
        e_commit = 1; e_we = in_we && in_rd != 0 && in_wb_sel != 2'b11;
        e_wr = in_rd; e_wd = (in_wb_sel == 2'b10) ? in_pc4 : in_alu;
        m_cnt++;
      end
    end else if (m_busy) begin
      if (flush) begin
        m_busy = 0; m_drain = !dmem_rvalid;
      end else if (dmem_rvalid) begin
        ref_load(m_f3, m_lo, dmem_rdata, ok, v);
        m_busy = 0; e_commit = 1; e_err = !ok;
        e_we = ok && m_we && m_rd != 0; e_wr = m_rd; e_wd = v;
        m_cnt++;
      end
    end else if (dmem_rvalid) m_drain = 0;
  endtask
  task automatic compare();
    chk("RegWe", RegWe, e_we);
    chk("misalign_err", misalign_err, e_err);
    chk("instret", instret, m_cnt % (1 << CW));
    chk("in_ready", in_ready, !m_busy && !m_drain);
    chk("load_busy", load_busy, m_busy);
    chk("load_rd", load_rd, m_busy ? m_rd : 5'd0);
    if (!e_commit || e_we) begin
      chk("RegWr", RegWr, e_wr);
      chk("RegWd", RegWd, e_wd);
    end
  endtask
  task automatic tick();
    predict();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask
  task automatic idle();
    in_valid = 0; in_wb_sel = 0; in_rd = 0; in_we = 0; in_alu = 0; in_pc4 = 0;
    in_funct3 = 0; in_addr_lo = 0; flush = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask
  task automatic load(logic [4:0] rd, logic [2:0] f3, logic [1:0] lo);
    idle(); in_valid = 1; in_wb_sel = 2'b01; in_rd = rd; in_we = 1; in_funct3 = f3; in_addr_lo = lo;
    tick();
  endtask
  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    compare();
    // ALU commit
    idle(); in_valid = 1; in_rd = 5; in_we = 1; in_alu = 32'h1234_5678;
    tick();
    chk("alu_we", RegWe, 1); chk("alu_wr", RegWr, 5); chk("alu_wd", RegWd, 32'h1234_5678); chk("alu_cnt", instret, 1);
    idle(); tick();
    chk("alu_we_drop", RegWe, 0);
    // LB / LBU at offset 3
    for (int u = 0; u < 2; u++) begin
      load(5'd3, u ? 3'b100 : 3'b000, 2'd3);
      chk("lb_ready", in_ready, 0); chk("lb_load_rd", load_rd, 3);
      idle(); tick(); tick();
      dmem_rvalid = 1; dmem_rdata = 32'h80FF_0000;
      tick();
      chk("lb_we", RegWe, 1);
      chk("lb_data", RegWd, u ? 32'h0000_0080 : 32'hFFFF_FF80);
      idle(); tick();
    end
    chk("lb_cnt", instret, 3);
    // LH misaligned
    load(5'd4, 3'b001, 2'd1);
    idle(); dmem_rvalid = 1; dmem_rdata = 32'hA5A5_A5A5;
    tick();
    chk("lh_err", misalign_err, 1); chk("lh_we", RegWe, 0); chk("lh_cnt", instret, 4);
    idle(); tick();
    chk("lh_err_drop", misalign_err, 0); chk("lh_ready", in_ready, 1);
    // LW flushed, then late response drained
    load(5'd7, 3'b010, 2'd0);
    idle(); flush = 1; tick();
    idle(); tick();
    chk("fl_ready", in_ready, 0);
    dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("fl_we", RegWe, 0); chk("fl_cnt", instret, 4); chk("fl_ready2", in_ready, 1);
    // ALU rd=0, then four back-to-back PC+4
    idle(); in_valid = 1; in_we = 1; in_alu = 32'hFFFF_0000;
    tick();
    chk("rd0_we", RegWe, 0); chk("rd0_cnt", instret, 5);
    for (int i = 0; i < 4; i++) begin
      idle(); in_valid = 1; in_wb_sel = 2'b10; in_rd = 5'(10 + i); in_we = 1; in_pc4 = 32'h100 + 32'(4 * i);
      tick();
      chk("pc4_we", RegWe, 1); chk("pc4_wd", RegWd, 32'h100 + 32'(4 * i)); chk("pc4_ready", in_ready, 1);
    end
    chk("pc4_cnt", instret, 9);
    // async reset during WAIT, late response ignored
    load(5'd9, 3'b010, 2'd0);
    idle(); tick();
    #2 rst_n = 0;
    model_reset();
    #1 compare();
    chk("rst_busy", load_busy, 0); chk("rst_cnt", instret, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    idle(); dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
    tick();
    chk("rst_we", RegWe, 0); chk("rst_cnt2", instret, 0); chk("rst_ready", in_ready, 1);
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      in_valid    = $urandom_range(0, 9) < 6;
      in_wb_sel   = 2'($urandom_range(0, 3));
      in_rd       = 5'($urandom_range(0, 31));
      in_we       = $urandom_range(0, 9) < 8;
      in_alu      = $urandom;
      in_pc4      = $urandom;
      in_funct3   = 3'($urandom_range(0, 7));
      in_addr_lo  = 2'($urandom_range(0, 3));
      flush       = $urandom_range(0, 9) == 0;
      dmem_rvalid = $urandom_range(0, 9) < 3;
      dmem_rdata  = $urandom;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
